i2c_slave: RTL and testbench

//  Target-side endpoint for the i2c_master bus: 7-bit address, write and read transfers.

---
 rtl/i2c_slave_pkg.sv | 25 ++
 rtl/i2c_slave_bus_sync.sv | 78 +++++++
 rtl/i2c_slave.sv | 234 +++++++++++++++++++++++
 tb/tb_i2c_slave.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/i2c_slave_pkg.sv
// ============================================================================
// i2c_slave_pkg : shared I2C state encoding and field indices
// Revision 1.0
// ============================================================================
`default_nettype none

package i2c_slave_pkg;

  localparam int unsigned STATE_W = 4;
  localparam int unsigned RW_BIT  = 0;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE     = 4'd0,
    ST_ADDR     = 4'd1,
    ST_ADDR_ACK = 4'd2,
    ST_RX_DATA  = 4'd3,
    ST_RX_ACK   = 4'd4,
    ST_TX_DATA  = 4'd5,
    ST_TX_ACK   = 4'd6,
    ST_IGNORE   = 4'd7
  } state_e;

endpackage

`default_nettype wire

// File: rtl/i2c_slave_bus_sync.sv
// ============================================================================
// i2c_bus_sync : 2-FF synchroniser and edge/START/STOP detector for SCL/SDA
// Revision 1.0
// ============================================================================
`default_nettype none

module i2c_bus_sync (
  input  logic clk,
  input  logic rst,
  input  logic scl_i,
  input  logic sda_i,
  output logic scl_s_o,
  output logic sda_s_o,
  output logic scl_rise_o,
  output logic scl_fall_o,
  output logic start_det_o,
  output logic stop_det_o
);

  logic [1:0] scl_sync_q;
  logic [1:0] sda_sync_q;
  logic       scl_prev_q;
  logic       sda_prev_q;
  logic       scl_s_q;
  logic       sda_s_q;
  logic       scl_rise_q;
  logic       scl_fall_q;
  logic       start_q;
  logic       stop_q;

  logic w_scl_rise;
  logic w_scl_fall;
  logic w_start;
  logic w_stop;

  // SDA edges are qualified by the previous SCL so a simultaneous SCL edge
  // cannot turn a data transition into a START/STOP.
  assign w_scl_rise =  scl_sync_q[1] & ~scl_prev_q;
  assign w_scl_fall = ~scl_sync_q[1] &  scl_prev_q;
  assign w_start    =  scl_prev_q & sda_prev_q & ~sda_sync_q[1];
  assign w_stop     =  scl_prev_q & ~sda_prev_q & sda_sync_q[1];

  always_ff @(posedge clk) begin
    if (rst) begin
      scl_sync_q <= 2'b11;
      sda_sync_q <= 2'b11;
      scl_prev_q <= 1'b1;
      sda_prev_q <= 1'b1;
      scl_s_q    <= 1'b1;
      sda_s_q    <= 1'b1;
      scl_rise_q <= 1'b0;
      scl_fall_q <= 1'b0;
      start_q    <= 1'b0;
      stop_q     <= 1'b0;
    end else begin
      scl_sync_q <= {scl_sync_q[0], scl_i};
      sda_sync_q <= {sda_sync_q[0], sda_i};
      scl_prev_q <= scl_sync_q[1];
      sda_prev_q <= sda_sync_q[1];
      scl_s_q    <= scl_sync_q[1];
      sda_s_q    <= sda_sync_q[1];
      scl_rise_q <= w_scl_rise;
      scl_fall_q <= w_scl_fall;
      start_q    <= w_start;
      stop_q     <= w_stop;
    end
  end

  assign scl_s_o     = scl_s_q;
  assign sda_s_o     = sda_s_q;
  assign scl_rise_o  = scl_rise_q;
  assign scl_fall_o  = scl_fall_q;
  assign start_det_o = start_q;
  assign stop_det_o  = stop_q;

endmodule

`default_nettype wire

// File: rtl/i2c_slave.sv
// ============================================================================
// i2c_slave : 7-bit address I2C target with byte-wide RX/TX local interface
// Revision 1.0
// ============================================================================
`default_nettype none

module i2c_slave
  import i2c_slave_pkg::*;
#(
  parameter logic [6:0] SLAVE_ADDR = 7'h50
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       scl_i,
  input  logic       sda_i,
  output logic       sda_oe_o,
  output logic [7:0] rx_data_o,
  output logic       rx_valid_o,
  input  logic [7:0] tx_data_i,
  output logic       tx_req_o,
  output logic       busy_o,
  output logic       addressed_o
);

  logic scl_s;
  logic sda_s;
  logic scl_rise;
  logic scl_fall;
  logic start_det;
  logic stop_det;

  i2c_bus_sync u_sync (
    .clk         (clk),
    .rst         (rst),
    .scl_i       (scl_i),
    .sda_i       (sda_i),
    .scl_s_o     (scl_s),
    .sda_s_o     (sda_s),
    .scl_rise_o  (scl_rise),
    .scl_fall_o  (scl_fall),
    .start_det_o (start_det),
    .stop_det_o  (stop_det)
  );

  state_e     state_q,     state_d;
  logic [2:0] bit_cnt_q,   bit_cnt_d;
  logic [7:0] shift_q,     shift_d;
  logic       phase_q,     phase_d;
  logic       sda_oe_q,    sda_oe_d;
  logic [7:0] rx_data_q,   rx_data_d;
  logic       rx_valid_q,  rx_valid_d;
  logic       tx_req_q,    tx_req_d;
  logic       busy_q,      busy_d;
  logic       addressed_q, addressed_d;

  logic [7:0] w_shift_in;
  logic       w_fall;

  assign w_shift_in = {shift_q[6:0], sda_s};
  // SDA is only ever retimed while SCL is known low.
  assign w_fall     = scl_fall & ~scl_s;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      bit_cnt_q   <= 3'd7;
      shift_q     <= 8'h00;
      phase_q     <= 1'b0;
      sda_oe_q    <= 1'b0;
      rx_data_q   <= 8'h00;
      rx_valid_q  <= 1'b0;
      tx_req_q    <= 1'b0;
      busy_q      <= 1'b0;
      addressed_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      phase_q     <= phase_d;
      sda_oe_q    <= sda_oe_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      tx_req_q    <= tx_req_d;
      busy_q      <= busy_d;
      addressed_q <= addressed_d;
    end
  end

  // phase_q: in ACK states, 0 = waiting to drive ACK, 1 = ACK driven;
  // in TX_DATA, 1 = all 8 bits clocked; in TX_ACK, 1 = master ACKed.
  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    phase_d     = phase_q;
    sda_oe_d    = sda_oe_q;
    rx_data_d   = rx_data_q;
    rx_valid_d  = 1'b0;
    tx_req_d    = 1'b0;
    busy_d      = busy_q;
    addressed_d = addressed_q;

    if (start_det) begin
      state_d     = ST_ADDR;
      bit_cnt_d   = 3'd7;
      phase_d     = 1'b0;
      sda_oe_d    = 1'b0;
      addressed_d = 1'b0;
      busy_d      = 1'b1;
    end else if (stop_det) begin
      state_d     = ST_IDLE;
      bit_cnt_d   = 3'd7;
      phase_d     = 1'b0;
      sda_oe_d    = 1'b0;
      addressed_d = 1'b0;
      busy_d      = 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          sda_oe_d = 1'b0;
        end
        ST_ADDR: begin
          if (scl_rise) begin
            shift_d = w_shift_in;
            if (bit_cnt_q == 3'd0) begin
              bit_cnt_d = 3'd7;
              phase_d   = 1'b0;
              state_d   = (w_shift_in[7:1] == SLAVE_ADDR) ? ST_ADDR_ACK : ST_IGNORE;
            end else begin
              bit_cnt_d = bit_cnt_q - 3'd1;
            end
          end
        end
        ST_ADDR_ACK: begin
          if (w_fall) begin
            if (!phase_q) begin
              sda_oe_d    = 1'b1;
              addressed_d = 1'b1;
              phase_d     = 1'b1;
            end else begin
              phase_d = 1'b0;
              if (shift_q[RW_BIT]) begin
                shift_d  = tx_data_i;
                tx_req_d = 1'b1;
                sda_oe_d = ~tx_data_i[7];
                state_d  = ST_TX_DATA;
              end else begin
                sda_oe_d = 1'b0;
                state_d  = ST_RX_DATA;
              end
            end
          end
        end
        ST_RX_DATA: begin
          if (scl_rise) begin
            shift_d = w_shift_in;
            if (bit_cnt_q == 3'd0) begin
              bit_cnt_d  = 3'd7;
              rx_data_d  = w_shift_in;
              rx_valid_d = 1'b1;
              phase_d    = 1'b0;
              state_d    = ST_RX_ACK;
            end else begin
              bit_cnt_d = bit_cnt_q - 3'd1;
            end
          end
        end
        ST_RX_ACK: begin
          if (w_fall) begin
            if (!phase_q) begin
              sda_oe_d = 1'b1;
              phase_d  = 1'b1;
            end else begin
              sda_oe_d = 1'b0;
              phase_d  = 1'b0;
              state_d  = ST_RX_DATA;
            end
          end
        end
        ST_TX_DATA: begin
          if (scl_rise) begin
            if (bit_cnt_q == 3'd0) begin
              bit_cnt_d = 3'd7;
              phase_d   = 1'b1;
            end else begin
              bit_cnt_d = bit_cnt_q - 3'd1;
              shift_d   = {shift_q[6:0], 1'b0};
            end
          end else if (w_fall) begin
            if (phase_q) begin
              sda_oe_d = 1'b0;
              phase_d  = 1'b0;
              state_d  = ST_TX_ACK;
            end else begin
              sda_oe_d = ~shift_q[7];
            end
          end
        end
        ST_TX_ACK: begin
          if (scl_rise) begin
            if (sda_s) begin
              state_d = ST_IGNORE;
            end else begin
              phase_d = 1'b1;
            end
          end else if (w_fall && phase_q) begin
            shift_d  = tx_data_i;
            tx_req_d = 1'b1;
            sda_oe_d = ~tx_data_i[7];
            phase_d  = 1'b0;
            state_d  = ST_TX_DATA;
          end
        end
        ST_IGNORE: begin
          sda_oe_d = 1'b0;
        end
        default: begin
          state_d  = ST_IDLE;
          sda_oe_d = 1'b0;
        end
      endcase
    end
  end

  assign sda_oe_o    = sda_oe_q;
  assign rx_data_o   = rx_data_q;
  assign rx_valid_o  = rx_valid_q;
  assign tx_req_o    = tx_req_q;
  assign busy_o      = busy_q;
  assign addressed_o = addressed_q;

endmodule

`default_nettype wire

// File: tb/tb_i2c_slave.sv
// ============================================================================
// tb_i2c_slave : bus-model bench with rx/tx scoreboard for i2c_slave
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_i2c_slave;

  localparam int T_LOW = 8;

  logic       clk;
  logic       rst;
  logic       m_scl;
  logic       m_sda;
  logic       sda_bus;
  logic       sda_oe_o;
  logic [7:0] rx_data_o;
  logic       rx_valid_o;
  logic [7:0] tx_data_i;
  logic       tx_req_o;
  logic       busy_o;
  logic       addressed_o;

  int n_checks = 0;
  int n_fail   = 0;
  int t_high   = 8;
  int rx_count = 0;
  int tx_count = 0;
  int oe_viol  = 0;
  logic oe_seen = 1'b0;

  logic [7:0] rx_q[$];
  logic [7:0] tx_q[$];

  // Wired-AND bus: the slave can only pull low.
  assign sda_bus = m_sda & ~sda_oe_o;

  i2c_slave #(.SLAVE_ADDR(7'h50)) u_dut (
    .clk         (clk),
    .rst         (rst),
    .scl_i       (m_scl),
    .sda_i       (sda_bus),
    .sda_oe_o    (sda_oe_o),
    .rx_data_o   (rx_data_o),
    .rx_valid_o  (rx_valid_o),
    .tx_data_i   (tx_data_i),
    .tx_req_o    (tx_req_o),
    .busy_o      (busy_o),
    .addressed_o (addressed_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  // Monitor: scoreboard pops plus the SDA-retiming rule.
  logic prev_oe, prev_scl_s, prev_evt, prev_rst;
  initial begin
    prev_oe = 1'b0; prev_scl_s = 1'b1; prev_evt = 1'b0; prev_rst = 1'b1;
  end
  always @(negedge clk) begin
    if (!rst) begin
      if (rx_valid_o) begin
        rx_count++;
        if (rx_q.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL rx_unexpected: got rx_valid with %0h, required none", rx_data_o);
        end else begin
          chk("rx_data", {24'd0, rx_data_o}, {24'd0, rx_q.pop_front()});
        end
      end
      if (tx_req_o) begin
        tx_count++;
        if (tx_q.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL tx_unexpected: got tx_req, required none");
        end else begin
          chk("tx_load", {24'd0, tx_data_i}, {24'd0, tx_q.pop_front()});
        end
      end
      if (sda_oe_o) oe_seen = 1'b1;
    end
    if ((sda_oe_o !== prev_oe) && prev_scl_s && !prev_evt && !rst && !prev_rst) begin
      oe_viol++;
      $display("FAIL oe_timing: sda_oe changed to %0b while scl high, required stable", sda_oe_o);
    end
    prev_oe    = sda_oe_o;
    prev_scl_s = u_dut.scl_s;
    prev_evt   = u_dut.start_det | u_dut.stop_det;
    prev_rst   = rst;
  end

  task automatic clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic bus_start();
    m_sda = 1'b1; clks(T_LOW);
    m_scl = 1'b1; clks(t_high);
    m_sda = 1'b0; clks(t_high);
    m_scl = 1'b0;
  endtask

  task automatic bus_stop();
    clks(2);
    m_sda = 1'b0; clks(T_LOW);
    m_scl = 1'b1; clks(t_high);
    m_sda = 1'b1; clks(t_high);
  endtask

  task automatic write_bit(input logic b);
    clks(2); m_sda = b; clks(T_LOW - 2);
    m_scl = 1'b1; clks(t_high);
    m_scl = 1'b0;
  endtask

  task automatic read_bit(output logic b);
    clks(2); m_sda = 1'b1; clks(T_LOW - 2);
    m_scl = 1'b1; clks(t_high / 2);
    b = sda_bus;
    clks(t_high - t_high / 2);
    m_scl = 1'b0;
  endtask

  task automatic write_byte(input logic [7:0] d, output logic ack);
    for (int i = 7; i >= 0; i--) write_bit(d[i]);
    read_bit(ack);
  endtask

  task automatic read8(output logic [7:0] d);
    logic b;
    for (int i = 7; i >= 0; i--) begin
      read_bit(b);
      d[i] = b;
    end
  endtask

  initial begin
    logic       ack;
    logic [7:0] rd;
    int         waited;
    rst = 1'b1; m_scl = 1'b1; m_sda = 1'b1; tx_data_i = 8'h00;
    clks(5);
    chk("reset_outputs", {21'd0, sda_oe_o, rx_data_o, rx_valid_o, tx_req_o, busy_o, addressed_o}, 32'd0);
    rst = 1'b0;
    clks(5);

    // 1: write A0 + A5
    rx_q.push_back(8'hA5);
    bus_start();
    chk("t1_busy", {31'd0, busy_o}, 32'd1);
    write_byte(8'hA0, ack);
    chk("t1_addr_ack", {31'd0, ack}, 32'd0);
    chk("t1_addressed", {31'd0, addressed_o}, 32'd1);
    write_byte(8'hA5, ack);
    chk("t1_data_ack", {31'd0, ack}, 32'd0);
    bus_stop();
    chk("t1_busy_after_stop", {31'd0, busy_o}, 32'd0);
    chk("t1_rx_count", rx_count, 32'd1);

    // 2: address 7'h51 is not ours
    oe_seen = 1'b0;
    bus_start();
    write_byte(8'hA2, ack);
    chk("t2_nack", {31'd0, ack}, 32'd1);
    write_byte(8'h77, ack);
    chk("t2_busy", {31'd0, busy_o}, 32'd1);
    chk("t2_addressed", {31'd0, addressed_o}, 32'd0);
    bus_stop();
    chk("t2_oe_never", {31'd0, oe_seen}, 32'd0);
    chk("t2_busy_after_stop", {31'd0, busy_o}, 32'd0);

    // 3: read two bytes, ACK then NACK
    tx_data_i = 8'h3C; tx_q.push_back(8'h3C);
    bus_start();
    write_byte(8'hA1, ack);
    chk("t3_addr_ack", {31'd0, ack}, 32'd0);
    read8(rd);
    chk("t3_byte0", {24'd0, rd}, 32'h3C);
    tx_data_i = 8'hC3; tx_q.push_back(8'hC3);
    write_bit(1'b0);
    read8(rd);
    chk("t3_byte1", {24'd0, rd}, 32'hC3);
    write_bit(1'b1);
    clks(T_LOW);
    chk("t3_ignore_oe", {31'd0, sda_oe_o}, 32'd0);
    chk("t3_ignore_state", {28'd0, u_dut.state_q}, 32'd7);
    bus_stop();
    chk("t3_tx_count", tx_count, 32'd2);

    // 4: write A0 + 12, repeated START, read A1
    rx_q.push_back(8'h12);
    bus_start();
    write_byte(8'hA0, ack);
    write_byte(8'h12, ack);
    chk("t4_data_ack", {31'd0, ack}, 32'd0);
    chk("t4_addressed_before", {31'd0, addressed_o}, 32'd1);
    bus_start();
    chk("t4_addressed_dropped", {31'd0, addressed_o}, 32'd0);
    chk("t4_busy_held", {31'd0, busy_o}, 32'd1);
    tx_data_i = 8'h96; tx_q.push_back(8'h96);
    write_byte(8'hA1, ack);
    chk("t4_readdr_ack", {31'd0, ack}, 32'd0);
    chk("t4_addressed_again", {31'd0, addressed_o}, 32'd1);
    read8(rd);
    chk("t4_read_byte", {24'd0, rd}, 32'h96);
    write_bit(1'b1);
    bus_stop();

    // 5a: STOP after 4 data bits
    bus_start();
    write_byte(8'hA0, ack);
    write_bit(1'b1); write_bit(1'b0); write_bit(1'b1); write_bit(1'b0);
    bus_stop();
    chk("t5_stop_idle", {29'd0, sda_oe_o, busy_o, addressed_o}, 32'd0);
    chk("t5_stop_state", {28'd0, u_dut.state_q}, 32'd0);

    // 5b: reset while the address ACK is being driven
    bus_start();
    for (int i = 7; i >= 0; i--) begin
      logic [7:0] a;
      a = 8'hA0;
      write_bit(a[i]);
    end
    waited = 0;
    while (!sda_oe_o && waited < 20) begin
      clks(1);
      waited++;
    end
    chk("t5_ack_driven", {31'd0, sda_oe_o}, 32'd1);
    rst = 1'b1;
    clks(1);
    chk("t5_rst_outputs", {21'd0, sda_oe_o, rx_data_o, rx_valid_o, tx_req_o, busy_o, addressed_o}, 32'd0);
    rst = 1'b0;
    m_sda = 1'b1; clks(T_LOW);
    m_scl = 1'b1; clks(T_LOW);
    chk("t5_idle_after_rst", {31'd0, busy_o}, 32'd0);

    // 6: minimum 4-clk SCL high time
    t_high = 4;
    rx_q.push_back(8'h5A);
    bus_start();
    write_byte(8'hA0, ack);
    chk("t6_addr_ack", {31'd0, ack}, 32'd0);
    write_byte(8'h5A, ack);
    chk("t6_data_ack", {31'd0, ack}, 32'd0);
    bus_stop();
    t_high = 8;
    clks(10);

    chk("rx_total", rx_count, 32'd3);
    chk("tx_total", tx_count, 32'd3);
    chk("rx_queue_empty", rx_q.size(), 32'd0);
    chk("tx_queue_empty", tx_q.size(), 32'd0);
    chk("oe_timing_violations", oe_viol, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
